// File: rtl/sc_bwacc_pkg.sv
// Shared definitions for the bitwise logic / accumulate unit: op codes,
// base-function encoding, accumulate FSM states and op decode helpers.
package sc_bwacc_pkg;

  // Operation codes as presented on SC_BWACC_op_In.
  localparam logic [2:0] OP_OR      = 3'b000;
  localparam logic [2:0] OP_AND     = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NOR     = 3'b011;
  localparam logic [2:0] OP_ACC_OR  = 3'b100;
  localparam logic [2:0] OP_ACC_AND = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_RSVD    = 3'b111;

  // Two-bit function select understood by sc_bitwise_op.
  localparam logic [1:0] FN_OR  = 2'b00;
  localparam logic [1:0] FN_AND = 2'b01;
  localparam logic [1:0] FN_XOR = 2'b10;
  localparam logic [1:0] FN_NOR = 2'b11;

  // Accumulate FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Base function of an op code. Accumulating ops reuse the low two bits
  // of their direct counterpart; the reserved code behaves as plain OR.
  function automatic logic [1:0] op_base_fn(input logic [2:0] op);
    if (op == OP_RSVD) begin
      return FN_OR;
    end
    return op[1:0];
  endfunction

  // True for the three accumulating op codes (reserved code is direct).
  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2] && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/sc_bitwise_op.sv
// Combinational two-operand bitwise function: y = a fn b.
module sc_bitwise_op
  import sc_bwacc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   fn_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  // Select the bitwise function of the two operands.
  always_comb begin
    y_o = a_i | b_i;
    case (fn_i)
      FN_OR:   y_o = a_i | b_i;
      FN_AND:  y_o = a_i & b_i;
      FN_XOR:  y_o = a_i ^ b_i;
      FN_NOR:  y_o = ~(a_i | b_i);
      default: y_o = a_i | b_i;
    endcase
  end

endmodule

// File: rtl/sc_bitwise_acc.sv
// Registered bitwise logic unit with valid/ready streaming on both sides.
// Direct ops produce one result per accepted beat; accumulating ops fold a
// multi-beat sequence (terminated by last) into a single result word.
//
// Handshake: a beat transfers on a rising edge where valid_In && ready_Out;
// a result transfers where valid_Out && ready_In. ready_Out is
// !valid_Out || ready_In, so the output register may be refilled on the
// same edge it is drained. Once valid_Out is raised, z_Out and count_Out
// stay stable until the result is taken.
module sc_bitwise_acc
  import sc_bwacc_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_COUNTWIDTH = 4
) (
  input  logic                         SC_BWACC_CLOCK_50,
  input  logic                         SC_BWACC_RESET_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0]  SC_BWACC_data0_In,
  input  logic [NUMBER_DATAWIDTH-1:0]  SC_BWACC_data1_In,
  input  logic [2:0]                   SC_BWACC_op_In,
  input  logic                         SC_BWACC_last_In,
  input  logic                         SC_BWACC_valid_In,
  output logic                         SC_BWACC_ready_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  SC_BWACC_z_Out,
  output logic [NUMBER_COUNTWIDTH-1:0] SC_BWACC_count_Out,
  output logic                         SC_BWACC_valid_Out,
  input  logic                         SC_BWACC_ready_In,
  output state_e                       SC_BWACC_state_Out
);

  localparam int W  = NUMBER_DATAWIDTH;
  localparam int CW = NUMBER_COUNTWIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Registered state and its next-state values.
  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [1:0]    fn_q, fn_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  z_q, z_d;
  logic [CW-1:0] cnt_out_q, cnt_out_d;
  logic          valid_q, valid_d;

  // Datapath intermediates.
  logic          accept;
  logic          beat_is_acc;
  logic [1:0]    term_fn;
  logic [W-1:0]  term;
  logic [W-1:0]  fold;
  logic [CW-1:0] count_inc;

  assign SC_BWACC_ready_Out = !valid_q || SC_BWACC_ready_In;
  assign accept             = SC_BWACC_valid_In && SC_BWACC_ready_Out;

  // Inside a sequence the latched function applies to every beat,
  // whatever op code the producer happens to present.
  assign term_fn     = (state_q == ACCUM) ? fn_q : op_base_fn(SC_BWACC_op_In);
  assign beat_is_acc = (state_q == ACCUM) || op_is_acc(SC_BWACC_op_In);
  assign count_inc   = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

  // Per-beat term: data0 fn data1.
  sc_bitwise_op #(.W(W)) u_term (
    .fn_i (term_fn),
    .a_i  (SC_BWACC_data0_In),
    .b_i  (SC_BWACC_data1_In),
    .y_o  (term)
  );

  // Accumulator fold: acc fn term, using the function latched at sequence start.
  sc_bitwise_op #(.W(W)) u_fold (
    .fn_i (fn_q),
    .a_i  (acc_q),
    .b_i  (term),
    .y_o  (fold)
  );

  // Next-state logic for the FSM, accumulator, beat counter and output register.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fn_d      = fn_q;
    count_d   = count_q;
    z_d       = z_q;
    cnt_out_d = cnt_out_q;
    valid_d   = valid_q && !SC_BWACC_ready_In;

    if (accept) begin
      if (!beat_is_acc) begin
        // Direct op in IDLE: result straight out, accumulator untouched.
        z_d       = term;
        cnt_out_d = CNT_ONE;
        valid_d   = 1'b1;
      end else if (state_q == IDLE) begin
        // First beat of a sequence seeds the accumulator.
        acc_d   = term;
        fn_d    = op_base_fn(SC_BWACC_op_In);
        count_d = CNT_ONE;
        if (SC_BWACC_last_In) begin
          z_d       = term;
          cnt_out_d = CNT_ONE;
          valid_d   = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end else begin
        // Subsequent beats fold into the accumulator.
        acc_d   = fold;
        count_d = count_inc;
        if (SC_BWACC_last_In) begin
          z_d       = fold;
          cnt_out_d = count_inc;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
    end
  end

  // State registers; reset discards any partial accumulation.
  always_ff @(posedge SC_BWACC_CLOCK_50 or posedge SC_BWACC_RESET_InHigh) begin
    if (SC_BWACC_RESET_InHigh) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      fn_q      <= FN_OR;
      count_q   <= '0;
      z_q       <= '0;
      cnt_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fn_q      <= fn_d;
      count_q   <= count_d;
      z_q       <= z_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
    end
  end

  assign SC_BWACC_z_Out     = z_q;
  assign SC_BWACC_count_Out = cnt_out_q;
  assign SC_BWACC_valid_Out = valid_q;
  assign SC_BWACC_state_Out = state_q;

endmodule
